// File: rtl/cl2_csr_hpm_cnt.sv
// cl2_csr_hpm_cnt: machine counter bank (mcycle, minstret, mhpmcounter3..N,
// mhpmevent3..N, mcountinhibit) for the cl2 RV32 core.
// Ports: clk_i/rst_i (sync, active-high); csr_we_i/csr_addr_i/csr_wdata_i
// write port; csr_hit_o/csr_rdata_o combinational read port;
// retire_i, evt_i count strobes; lcof_irq_o counter-overflow request.
// Optional macro CL2_HPM_SSCOFPMF_EN adds Sscofpmf OF bits (mhpmeventhK)
// and a registered lcof_irq_o; without it lcof_irq_o is tied low.

module cl2_csr_hpm_cnt #(
  parameter int CNT_WIDTH = 64,
  parameter int NUM_HPM   = 4,
  parameter int NUM_EVT   = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               csr_we_i,
  input  logic [11:0]        csr_addr_i,
  input  logic [31:0]        csr_wdata_i,
  output logic               csr_hit_o,
  output logic [31:0]        csr_rdata_o,
  input  logic               retire_i,
  input  logic [NUM_EVT-1:0] evt_i,
  output logic               lcof_irq_o
);

  // counter slot 0 = mcycle, 1 = minstret, 2+k = mhpmcounter(3+k)
  localparam int NC = 2 + NUM_HPM;
  localparam int HN = (NUM_HPM > 0) ? NUM_HPM : 1;
  localparam int EW = $clog2(NUM_EVT + 1);
  localparam int HW = CNT_WIDTH - 32;

  function automatic logic [31:0] inh_mask(int n);
    logic [31:0] m;
    m = 32'h0000_0005;
    for (int i = 0; i < n; i++) m[3+i] = 1'b1;
    return m;
  endfunction

  localparam logic [31:0] INH_MASK = inh_mask(NUM_HPM);

  // CSR counter number of a storage slot
  function automatic int csr_idx(int j);
    return (j == 0) ? 0 : j + 1;
  endfunction

  logic [CNT_WIDTH-1:0] cnt_q [NC];
  logic [CNT_WIDTH-1:0] cnt_d [NC];
  logic [EW-1:0]        evsel_q [HN];
  logic [31:0]          inh_q;

  logic [NC-1:0] inc;
  logic [NC-1:0] wr_lo;
  logic [NC-1:0] wr_hi;
  logic [HN-1:0] evm;
  logic [HN-1:0] ev_we;
  logic          inh_we;

  // event match: selector in 1..NUM_EVT and that strobe is high
  always_comb begin
    evm = '0;
    for (int k = 0; k < NUM_HPM; k++) begin
      for (int e = 1; e <= NUM_EVT; e++) begin
        if (evsel_q[k] == EW'(e) && evt_i[e-1]) evm[k] = 1'b1;
      end
    end
  end

  always_comb begin
    inc    = '0;
    inc[0] = ~inh_q[0];
    inc[1] = retire_i & ~inh_q[2];
    for (int k = 0; k < NUM_HPM; k++) begin
      inc[2+k] = evm[k] & ~inh_q[3+k];
    end
  end

  // write decode
  always_comb begin
    wr_lo  = '0;
    wr_hi  = '0;
    ev_we  = '0;
    inh_we = csr_we_i && (csr_addr_i == 12'h320);
    for (int j = 0; j < NC; j++) begin
      wr_lo[j] = csr_we_i &&
                 (csr_addr_i == (12'hB00 | 12'(csr_idx(j))));
      wr_hi[j] = csr_we_i &&
                 (csr_addr_i == (12'hB80 | 12'(csr_idx(j))));
    end
    for (int k = 0; k < NUM_HPM; k++) begin
      ev_we[k] = csr_we_i &&
                 (csr_addr_i == (12'h320 | 12'(3 + k)));
    end
  end

  // a CSR write to a counter suppresses its increment that cycle;
  // the full-width add carries straight into the high half
  always_comb begin
    for (int j = 0; j < NC; j++) begin
      cnt_d[j] = cnt_q[j];
      if (wr_lo[j]) begin
        cnt_d[j] = {cnt_q[j][CNT_WIDTH-1:32], csr_wdata_i};
      end else if (wr_hi[j]) begin
        cnt_d[j] = {csr_wdata_i[HW-1:0], cnt_q[j][31:0]};
      end else if (inc[j]) begin
        cnt_d[j] = cnt_q[j] + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int j = 0; j < NC; j++) cnt_q[j] <= '0;
      for (int k = 0; k < HN; k++) evsel_q[k] <= '0;
      inh_q <= '0;
    end else begin
      for (int j = 0; j < NC; j++) cnt_q[j] <= cnt_d[j];
      for (int k = 0; k < NUM_HPM; k++) begin
        if (ev_we[k]) evsel_q[k] <= csr_wdata_i[EW-1:0];
      end
      if (inh_we) inh_q <= csr_wdata_i & INH_MASK;
    end
  end

`ifdef CL2_HPM_SSCOFPMF_EN
  logic [HN-1:0] of_q;
  logic [HN-1:0] ovf;
  logic [HN-1:0] evh_we;
  logic          irq_q;

  // overflow only through an increment from all-ones, never via a write
  always_comb begin
    ovf    = '0;
    evh_we = '0;
    for (int k = 0; k < NUM_HPM; k++) begin
      evh_we[k] = csr_we_i &&
                  (csr_addr_i == (12'h720 | 12'(3 + k)));
      ovf[k] = inc[2+k] & ~wr_lo[2+k] & ~wr_hi[2+k] &
               (&cnt_q[2+k]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      of_q  <= '0;
      irq_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_HPM; k++) begin
        if (evh_we[k]) of_q[k] <= csr_wdata_i[31];
        else if (ovf[k]) of_q[k] <= 1'b1;
      end
      irq_q <= |of_q;
    end
  end

  assign lcof_irq_o = irq_q;
`else
  assign lcof_irq_o = 1'b0;
`endif

  // read mux: unimplemented counters 3..31 hit and read zero
  always_comb begin
    csr_hit_o   = 1'b0;
    csr_rdata_o = '0;
    if (csr_addr_i == 12'h320) begin
      csr_hit_o   = 1'b1;
      csr_rdata_o = inh_q;
    end
    for (int i = 0; i < 32; i++) begin
      if (i != 1 &&
          (csr_addr_i == (12'hB00 | 12'(i)) ||
           csr_addr_i == (12'hB80 | 12'(i)))) begin
        csr_hit_o = 1'b1;
      end
      if (i >= 3 && csr_addr_i == (12'h320 | 12'(i))) begin
        csr_hit_o = 1'b1;
      end
`ifdef CL2_HPM_SSCOFPMF_EN
      if (i >= 3 && csr_addr_i == (12'h720 | 12'(i))) begin
        csr_hit_o = 1'b1;
      end
`endif
    end
    for (int j = 0; j < NC; j++) begin
      if (csr_addr_i == (12'hB00 | 12'(csr_idx(j)))) begin
        csr_rdata_o = cnt_q[j][31:0];
      end
      if (csr_addr_i == (12'hB80 | 12'(csr_idx(j)))) begin
        csr_rdata_o = 32'(cnt_q[j][CNT_WIDTH-1:32]);
      end
    end
    for (int k = 0; k < NUM_HPM; k++) begin
      if (csr_addr_i == (12'h320 | 12'(3 + k))) begin
        csr_rdata_o = 32'(evsel_q[k]);
      end
`ifdef CL2_HPM_SSCOFPMF_EN
      if (csr_addr_i == (12'h720 | 12'(3 + k))) begin
        csr_rdata_o = {of_q[k], 31'b0};
      end
`endif
    end
  end

endmodule
